// File: rtl/counter_pkg.sv
// Shared types, defaults and helpers for the event counter primitive.
// Imported by edge_detect_rise and event_counter.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_MODULUS = 64;

    // Values outside the legal range collapse onto the top count state.
    function automatic int unsigned clamp_init(
        input int unsigned value,
        input int unsigned modulus
    );
        return (value >= modulus) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for the event input, one-cycle event pulse out.
// EVENT_COUNTER_SYNC_EN inserts a two-flop synchroniser ahead of detection.
module edge_detect_rise
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic evt
);

    logic a_s;
    logic a_q;

`ifdef EVENT_COUNTER_SYNC_EN
    logic s1;
    logic s2;

    // Two-stage synchroniser; reset high so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= a;
            s2 <= s1;
        end
    end

    assign a_s = s2;
`else
    assign a_s = a;
`endif

    // Edge history; reset high so an input already high is not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q <= 1'b1;
        end else begin
            a_q <= a_s;
        end
    end

    assign evt = a_s & ~a_q;

endmodule

// File: rtl/event_counter.sv
// Modulo up/down event counter with preload, wrap/saturate, tc pulse and sticky ovf.
// Optional macro EVENT_COUNTER_SYNC_EN adds a synchroniser on a (latency 3 clocks).
module event_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] initValue,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam cnt_mode_e        MODE   = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP_M1 = WIDTH'(MODULUS - 2);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic             evt;
    logic [WIDTH-1:0] init_c;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             ovf_set;

    edge_detect_rise u_edge (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .evt (evt)
    );

    assign init_c = WIDTH'(clamp_init(32'(initValue), MODULUS));

    // Next count: load beats a step; boundaries compare against TOP, never rely on rollover.
    always_comb begin
        cnt_nxt = count;
        tc_nxt  = 1'b0;
        ovf_set = 1'b0;
        if (load) begin
            cnt_nxt = init_c;
        end else if (evt && en) begin
            if (up) begin
                if (count >= TOP) begin
                    ovf_set = 1'b1;
                    if (MODE == CNT_WRAP) begin
                        cnt_nxt = '0;
                    end
                end else begin
                    cnt_nxt = count + ONE;
                    tc_nxt  = (count == TOP_M1);
                end
            end else begin
                if (count == '0) begin
                    ovf_set = 1'b1;
                    if (MODE == CNT_WRAP) begin
                        cnt_nxt = TOP;
                    end
                end else begin
                    cnt_nxt = count - ONE;
                    tc_nxt  = (count == ONE);
                end
            end
        end
    end

    // State registers; a coincident ovf set overrides the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= init_c;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= cnt_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_set | (ovf & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_event_counter.sv
// Scoreboard bench for event_counter: three configurations share stimulus,
// expectations are queued at the clock edge and checked on the falling edge.
module tb_event_counter;

`ifdef EVENT_COUNTER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int         id;
        logic [5:0] cnt;
        logic       tc;
        logic       ovf;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       en;
    logic       up;
    logic       load;
    logic       clr_ovf;
    logic [5:0] init6;
    logic [3:0] init4;

    logic [5:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    event_counter u0 (
        .clk(clk), .rst(rst), .a(a), .en(en), .up(up), .load(load),
        .initValue(init6), .clr_ovf(clr_ovf),
        .count(c0), .tc(tc0), .ovf(ovf0)
    );

    event_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .a(a), .en(en), .up(up), .load(load),
        .initValue(init4), .clr_ovf(clr_ovf),
        .count(c1), .tc(tc1), .ovf(ovf1)
    );

    event_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst), .a(a), .en(en), .up(up), .load(load),
        .initValue(init4), .clr_ovf(clr_ovf),
        .count(c2), .tc(tc2), .ovf(ovf2)
    );

    // Monitor: compare every expectation queued at the preceding rising edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] ac;
        logic       at;
        logic       ao;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.id)
                0:       begin ac = c0;         at = tc0; ao = ovf0; end
                1:       begin ac = {2'b00, c1}; at = tc1; ao = ovf1; end
                default: begin ac = {2'b00, c2}; at = tc2; ao = ovf2; end
            endcase
            checks++;
            if (ac !== e.cnt || at !== e.tc || ao !== e.ovf) begin
                errors++;
                $display("FAIL %s dut%0d: got cnt=%0d tc=%b ovf=%b, expected cnt=%0d tc=%b ovf=%b",
                         e.tag, e.id, ac, at, ao, e.cnt, e.tc, e.ovf);
            end
        end
    end

    task automatic push(input int id, input int cnt, input logic t,
                        input logic o, input string tag);
        exp_t e;
        e.id  = id;
        e.cnt = 6'(cnt);
        e.tc  = t;
        e.ovf = o;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        repeat (LAT + 1) tick();
    endtask

    task automatic do_reset(input int r0, input int r1, input int r2);
        rst = 1'b0;
        tick();
        @(posedge clk);
        push(0, r0, 1'b0, 1'b0, "reset");
        push(1, r1, 1'b0, 1'b0, "reset");
        push(2, r2, 1'b0, 1'b0, "reset");
        #1;
        rst = 1'b1;
    endtask

    task automatic cyc(input logic ld, input logic c, input int id,
                       input int cnt, input logic t, input logic o,
                       input string tag);
        load    = ld;
        clr_ovf = c;
        @(posedge clk);
        push(id, cnt, t, o, tag);
        #1;
        load    = 1'b0;
        clr_ovf = 1'b0;
    endtask

    // One rising edge on a; load/clr line up with the edge where the event lands.
    task automatic ev(input logic e, input logic u, input logic ld,
                      input logic c, input int id, input int cnt,
                      input logic t, input logic o, input string tag);
        a       = 1'b1;
        en      = e;
        up      = u;
        clr_ovf = c;
        load    = (LAT == 1) ? ld : 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            if (k == LAT) push(id, cnt, t, o, tag);
            #1;
            a    = 1'b0;
            load = (k == LAT - 1) ? ld : 1'b0;
        end
        clr_ovf = 1'b0;
        @(posedge clk);
        push(id, cnt, 1'b0, o, {tag, "_idle"});
        #1;
        en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        a = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; clr_ovf = 1'b0;
        init6 = 6'd0; init4 = 4'd0; rst = 1'b0;

        do_reset(0, 0, 0);
        flush();

        for (int i = 1; i <= 5; i++) begin
            ev(1'b1, 1'b1, 1'b0, 1'b0, 0, i, 1'b0, 1'b0, "t1_up");
        end

        init4 = 4'd8;
        cyc(1'b1, 1'b0, 1, 8, 1'b0, 1'b0, "t2_load8");
        ev(1'b1, 1'b1, 1'b0, 1'b0, 1, 9, 1'b1, 1'b0, "t2_to9");
        ev(1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1, "t2_wrap");
        cyc(1'b0, 1'b1, 1, 0, 1'b0, 1'b0, "t2_clr");
        init4 = 4'd9;
        cyc(1'b1, 1'b0, 1, 9, 1'b0, 1'b0, "t2_load9");
        ev(1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 1'b1, "t2_set_wins");
        cyc(1'b0, 1'b0, 2, 9, 1'b0, 1'b1, "t2_sat_hold");

        init4 = 4'd1;
        cyc(1'b1, 1'b0, 2, 1, 1'b0, 1'b1, "t3_load_keeps_ovf");
        cyc(1'b0, 1'b1, 2, 1, 1'b0, 1'b0, "t3_clr");
        ev(1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0, "t3_dn0");
        ev(1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1, "t3_block1");
        ev(1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1, "t3_block2");

        a = 1'b1; init6 = 6'd20; init4 = 4'd12;
        do_reset(20, 9, 9);
        cyc(1'b0, 1'b0, 0, 20, 1'b0, 1'b0, "t4_held");
        cyc(1'b0, 1'b0, 0, 20, 1'b0, 1'b0, "t4_held");
        a = 1'b0;
        flush();
        cyc(1'b0, 1'b0, 0, 20, 1'b0, 1'b0, "t4_low");
        ev(1'b1, 1'b1, 1'b0, 1'b0, 0, 21, 1'b0, 1'b0, "t4_step");
        ev(1'b0, 1'b1, 1'b0, 1'b0, 0, 21, 1'b0, 1'b0, "t4_en0");

        ev(1'b1, 1'b1, 1'b1, 1'b0, 1, 9, 1'b0, 1'b1, "t5_load_evt");

        a = 1'b1;
        do_reset(20, 9, 9);
        cyc(1'b0, 1'b0, 0, 20, 1'b0, 1'b0, "t5_mid_rst");
        a = 1'b0;
        flush();

        a = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            push(0, (k == LAT) ? 21 : 20, 1'b0, 1'b0, "t6_latency");
            #1;
            a = 1'b0;
        end
        cyc(1'b0, 1'b0, 0, 21, 1'b0, 1'b0, "t6_after");

        repeat (2) tick();
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_counter.md
Name: event_counter

Overview:
Parametrised successor to the lab 6-bit event counter. Counts rising edges of a single-bit event input `a` (sampled on `clk`), with enable, up/down direction, synchronous preload, a modulus, and wrap or saturate boundary mode. Provides a terminal-count pulse and a sticky overflow flag. Used as the generic counting primitive for lab exercises feeding displays and FSMs.

Parameters:
WIDTH, 6, bit width of `count` and `initValue`.
MODULUS, 2**WIDTH, number of count states; legal count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 means wrap at the boundary; 1 means hold at the boundary.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous reset, active-low.
a  in  1  event input; each 0->1 transition seen at `clk` is one event.
en  in  1  count enable; events arriving while en=0 are discarded.
up  in  1  direction; 1 counts up, 0 counts down.
load  in  1  synchronous preload of `initValue`.
initValue  in  WIDTH  reset and preload value.
clr_ovf  in  1  clears the sticky `ovf` flag.
count  out  WIDTH  current count.
tc  out  1  terminal-count pulse.
ovf  out  1  sticky boundary-crossing flag.

Behaviour:
- Clamped init value: initValue >= MODULUS is treated as MODULUS-1 wherever it is loaded.
- Reset: rst=0 at a posedge sets count to the clamped initValue, tc=0, ovf=0, and the edge-history flop a_q=1. Because a_q resets to 1, an `a` held high through reset is not counted.
- Event detection: event = a & ~a_q. a_q <= a on every non-reset edge, regardless of en and load.
- Latency: one clock. count changes on the posedge at which `a` is first sampled high.
- Priority, highest first: rst, then load, then (event & en).
- Load: count <= clamped initValue and tc <= 0; ovf is unchanged. A coincident event is dropped.
- Up step, count < MODULUS-1: count+1.
- Up step, count == MODULUS-1: count becomes 0 (SATURATE=0) or holds (SATURATE=1); ovf <= 1 in both modes.
- Down step, count > 0: count-1.
- Down step, count == 0: count becomes MODULUS-1 (SATURATE=0) or holds at 0 (SATURATE=1); ovf <= 1 in both modes.
- tc: registered; high for exactly one cycle after a step lands count on the terminal value (MODULUS-1 when up=1, 0 when up=0). A blocked step in saturate mode does not re-pulse tc. tc is 0 after load and after reset.
- ovf: sticky. Cleared when clr_ovf=1. If set and clear occur in the same cycle, set wins.
- Direction change: `up` is sampled only on the event cycle; there is no other state to flush.
- Arithmetic: all arithmetic is WIDTH bits with an explicit compare against MODULUS-1. Wrap must never rely on natural 2**WIDTH rollover when MODULUS < 2**WIDTH.
- Reset mid-count: takes effect on the next posedge; a pending event in that cycle is dropped.

Optional Feature:
EVENT_COUNTER_SYNC_EN
- Defined: a two-flop synchroniser sits on `a` ahead of edge detection. Both flops reset to 1. Latency from `a` rising to count change becomes 3 clocks.
- Undefined: `a` feeds edge detection directly; latency is 1 clock. `a` must then be synchronous to clk.

Decomposition:
- Package counter_pkg:
  - typedef enum {CNT_WRAP, CNT_SAT} cnt_mode_e, mapped to SATURATE.
  - function clamp_init(value, modulus).
  - localparam defaults DEF_WIDTH=6, DEF_MODULUS=64.
- One sub-module, edge_detect_rise: a_q register (reset value 1) plus the optional synchroniser; outputs a one-cycle event.
- event_counter contains the count register, boundary logic, tc and ovf.

Test Plan:
- Reset with initValue=0; then `a` toggles 0/1 every cycle for 5 rising edges, en=1, up=1 -> count steps 1,2,3,4,5; tc=0, ovf=0.
- WIDTH=4, MODULUS=10, SATURATE=0, load initValue=8, then 2 up events -> count 9 (tc pulses one cycle), then 0 with ovf=1. clr_ovf=1 -> ovf=0. clr_ovf coincident with a new wrap -> ovf stays 1.
- SATURATE=1, MODULUS=10, count=1, up=0, 3 events -> count 0 (tc pulse), then 0 and 0 with ovf=1 and no second tc.
- `a` held high through reset release -> count unchanged. Then a=0 followed by a=1 -> count+1 exactly once. en=0 during an edge -> no change.
- load=1 and event in the same cycle with initValue=12, MODULUS=10 -> count=9 (clamped), event ignored, tc=0. rst=0 asserted mid-sequence -> count returns to the clamped initValue on the next edge.
- With EVENT_COUNTER_SYNC_EN defined: single `a` rising edge -> count changes on the 3rd posedge. Without the macro: on the 1st posedge.
